// File: rtl/reg_bank_pkg.sv
// Shared definitions for the reg_bank register file: default widths and the
// clear-sequencer state encoding.
package reg_bank_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

endpackage : reg_bank_pkg

// File: rtl/reg_bank_rdport.sv
// One registered read port of reg_bank: address mux, optional write bypass
// (enabled by macro REG_BANK_BYPASS_EN), output data register and valid flag.
module reg_bank_rdport
   import reg_bank_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   input  logic [DATA_W-1:0] regs_i [2**ADDR_W],
   input  logic              wr_hit_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              rd_valid_o
);

   logic [DATA_W-1:0] rd_data_d;
   logic [DATA_W-1:0] rd_data_q;
   logic              rd_valid_q;

   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en_i) begin
         if (rd_addr_i == '0) begin
            rd_data_d = '0;
         end else begin
            rd_data_d = regs_i[rd_addr_i];
`ifdef REG_BANK_BYPASS_EN
            // wr_hit_i is only raised for accepted, nonzero-address writes
            if (wr_hit_i && (wr_addr_i == rd_addr_i)) begin
               rd_data_d = wr_data_i;
            end
`endif
         end
      end
   end

`ifndef REG_BANK_BYPASS_EN
   logic unused_bypass;
   assign unused_bypass = ^{wr_hit_i, wr_addr_i, wr_data_i};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_en_i;
      end
   end

   assign rd_data_o  = rd_data_q;
   assign rd_valid_o = rd_valid_q;

endmodule : reg_bank_rdport

// File: rtl/reg_bank.sv
// Register bank with one write port, two registered read ports and a
// sequenced full-bank clear. Optional read-during-write bypass: REG_BANK_BYPASS_EN.
module reg_bank
   import reg_bank_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en_a,
   input  logic [ADDR_W-1:0] rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   output logic              rd_valid_a,
   input  logic              rd_en_b,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b,
   output logic              rd_valid_b,
   input  logic              clr,
   output logic              busy,
   output state_t            dbg_state
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   state_t            state_q;
   logic [ADDR_W-1:0] idx_q;
   logic              busy_q;
   logic              wr_accept_d;

   // Address 0 is hardwired to zero, so writes to it never land.
   assign wr_accept_d = wr_en && !busy_q && (wr_addr != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else if (state_q == CLEAR) begin
         regs_q[idx_q] <= '0;
      end else if (wr_accept_d) begin
         regs_q[wr_addr] <= wr_data;
      end
   end

   // Clear sequencer: index walks 1..DEPTH-1, one register zeroed per cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (clr) begin
                  state_q <= CLEAR;
                  idx_q   <= ADDR_W'(1);
                  busy_q  <= 1'b1;
               end
            end
            CLEAR: begin
               if (idx_q == '1) begin
                  state_q <= IDLE;
                  idx_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  idx_q <= idx_q + ADDR_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               idx_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign dbg_state = state_q;

   reg_bank_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rdport_a (
      .clk        (clk),
      .rst        (rst),
      .rd_en_i    (rd_en_a),
      .rd_addr_i  (rd_addr_a),
      .regs_i     (regs_q),
      .wr_hit_i   (wr_accept_d),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data),
      .rd_data_o  (rd_data_a),
      .rd_valid_o (rd_valid_a)
   );

   reg_bank_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rdport_b (
      .clk        (clk),
      .rst        (rst),
      .rd_en_i    (rd_en_b),
      .rd_addr_i  (rd_addr_b),
      .regs_i     (regs_q),
      .wr_hit_i   (wr_accept_d),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data),
      .rd_data_o  (rd_data_b),
      .rd_valid_o (rd_valid_b)
   );

endmodule : reg_bank

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank (default 32x32 configuration).
module tb_reg_bank;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        rd_en_a;
   logic [4:0]  rd_addr_a;
   logic [31:0] rd_data_a;
   logic        rd_valid_a;
   logic        rd_en_b;
   logic [4:0]  rd_addr_b;
   logic [31:0] rd_data_b;
   logic        rd_valid_b;
   logic        clr;
   logic        busy;
   reg_bank_pkg::state_t dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   int busy_cycles;

   reg_bank dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_en_a    (rd_en_a),
      .rd_addr_a  (rd_addr_a),
      .rd_data_a  (rd_data_a),
      .rd_valid_a (rd_valid_a),
      .rd_en_b    (rd_en_b),
      .rd_addr_b  (rd_addr_b),
      .rd_data_b  (rd_data_b),
      .rd_valid_b (rd_valid_b),
      .clr        (clr),
      .busy       (busy),
      .dbg_state  (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input logic [4:0] a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic read_a(input logic [4:0] a);
      rd_en_a = 1'b1; rd_addr_a = a;
      tick();
      rd_en_a = 1'b0;
   endtask

   task automatic fill_index();
      for (int i = 1; i < 32; i++) write(5'(i), 32'(i));
   endtask

   task automatic run_clear(input bit attempt_write);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      busy_cycles = 0;
      if (attempt_write) begin
         wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'hFFFF_FFFF;
         rd_en_a = 1'b1; rd_addr_a = 5'd20;
      end
      while (busy && busy_cycles < 100) begin
         busy_cycles++;
         tick();
         if (busy_cycles == 1 && attempt_write) begin
            check("read_during_busy_data", rd_data_a, 32'd20);
            check("read_during_busy_valid", {31'd0, rd_valid_a}, 32'd1);
            rd_en_a = 1'b0;
         end
      end
      wr_en = 1'b0;
      check("busy_cycles", 32'(busy_cycles), 32'd31);
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 32; i++) begin
         read_a(5'(i));
         check(tag, rd_data_a, 32'd0);
      end
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_en_a = 1'b0; rd_addr_a = '0; rd_en_b = 1'b0; rd_addr_b = '0; clr = 1'b0;
      #1;
      check("reset_rd_data_a", rd_data_a, 32'd0);
      check("reset_rd_valid_a", {31'd0, rd_valid_a}, 32'd0);
      check("reset_rd_data_b", rd_data_b, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_state", 32'(dbg_state), 32'(reg_bank_pkg::IDLE));
      tick(); tick();
      rst = 1'b0;
      tick();

      write(5'd7, 32'hDEAD_BEEF);
      read_a(5'd7);
      check("wr7_rd_a_data", rd_data_a, 32'hDEAD_BEEF);
      check("wr7_rd_a_valid", {31'd0, rd_valid_a}, 32'd1);
      tick();
      check("idle_valid_low", {31'd0, rd_valid_a}, 32'd0);
      check("idle_data_held", rd_data_a, 32'hDEAD_BEEF);

      write(5'd0, 32'h1234_5678);
      rd_en_b = 1'b1; rd_addr_b = 5'd0;
      tick();
      rd_en_b = 1'b0;
      check("reg0_rd_b_data", rd_data_b, 32'd0);
      check("reg0_rd_b_valid", {31'd0, rd_valid_b}, 32'd1);

      write(5'd3, 32'h0000_0001);
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5_A5A5;
      rd_en_a = 1'b1; rd_addr_a = 5'd3;
      tick();
      wr_en = 1'b0; rd_en_a = 1'b0;
`ifdef REG_BANK_BYPASS_EN
      check("collision_rd_a", rd_data_a, 32'hA5A5_A5A5);
`else
      check("collision_rd_a", rd_data_a, 32'h0000_0001);
`endif
      read_a(5'd3);
      check("after_collision_rd_a", rd_data_a, 32'hA5A5_A5A5);

      write(5'd5, 32'h0000_0055);
      rd_en_a = 1'b1; rd_addr_a = 5'd5; rd_en_b = 1'b1; rd_addr_b = 5'd5;
      tick();
      rd_en_a = 1'b0; rd_en_b = 1'b0;
      check("dual_rd_a_data", rd_data_a, 32'h55);
      check("dual_rd_b_data", rd_data_b, 32'h55);
      check("dual_rd_a_valid", {31'd0, rd_valid_a}, 32'd1);
      check("dual_rd_b_valid", {31'd0, rd_valid_b}, 32'd1);

      fill_index();
      rd_en_a = 1'b1; rd_addr_a = 5'd31; rd_en_b = 1'b1; rd_addr_b = 5'd1;
      tick();
      rd_en_a = 1'b0; rd_en_b = 1'b0;
      check("fill_rd_a31", rd_data_a, 32'd31);
      check("fill_rd_b1", rd_data_b, 32'd1);

      run_clear(1'b1);
      check("clear_state_idle", 32'(dbg_state), 32'(reg_bank_pkg::IDLE));
      check_all_zero("after_clear_zero");

      fill_index();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      for (int i = 1; i < 10; i++) tick();
      check("midclear_busy", {31'd0, busy}, 32'd1);
      rd_en_a = 1'b1; rd_addr_a = 5'd30;
      tick();
      rd_en_a = 1'b0;
      check("midclear_rd_data", rd_data_a, 32'd30);
      check("midclear_rd_valid", {31'd0, rd_valid_a}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_busy", {31'd0, busy}, 32'd0);
      check("async_rst_valid_a", {31'd0, rd_valid_a}, 32'd0);
      check("async_rst_data_a", rd_data_a, 32'd0);
      check("async_rst_state", 32'(dbg_state), 32'(reg_bank_pkg::IDLE));
      tick();
      rst = 1'b0;
      check_all_zero("after_abort_zero");
      run_clear(1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_reg_bank
